// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Memory/writeback pipeline stage. It takes the registered execute-stage
// outputs and produces one register-file write port plus branch/jump pulses.
// Loads and stores use an internal word RAM with MEM_LAT wait states. While a
// memory op is in flight, stall holds the upstream stage.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   -> a load/store with alu_in[1:0] != 0 skips the RAM access and
//                the writeback, and pulses align_err at its commit cycle
//   undefined -> align_err is constant 0 and alu_in[1:0] is ignored
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   valid_in         upstream presents a live instruction
//   alu_in           execute result; byte address for load/store
//   opcode_in        4-bit opcode
//   regdst_in        destination register index
//   read_data2_in    store data
//   cmp_in           A==B flag from execute
//   stall            high while a memory op is pending (registered)
//   wb_en            one-cycle register write strobe
//   wb_addr/wb_data  register write index/data (held while wb_en=0)
//   branch_taken     one-cycle pulse, conditional branch taken
//   jump_taken       one-cycle pulse, jump retired
//   align_err        one-cycle pulse, misaligned load/store
// ---------------------------------------------------------------------------
// state  | meaning
// S_IDLE | ready; accepts an instruction on valid_in
// S_WAIT | memory op latched; r_cnt counts down the wait states
// ---------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [31:0] alu_in,
   input  logic [3:0]  opcode_in,
   input  logic [3:0]  regdst_in,
   input  logic [31:0] read_data2_in,
   input  logic        cmp_in,
   output logic        stall,
   output logic        wb_en,
   output logic [3:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        branch_taken,
   output logic        jump_taken,
   output logic        align_err
);

   localparam logic [3:0] OP_LOAD  = 4'b0100;
   localparam logic [3:0] OP_STORE = 4'b0101;
   localparam logic [3:0] OP_BEQ   = 4'b0110;
   localparam logic [3:0] OP_BNE   = 4'b0111;
   localparam logic [3:0] OP_JMP   = 4'b1010;
   localparam bit         LAT0     = (MEM_LAT == 0);
   localparam logic [2:0] LAT3     = 3'(MEM_LAT);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t              r_state;
   logic [2:0]          r_cnt;
   logic                r_is_load;
   logic                r_mis;
   logic [ADDR_W-1:0]   r_idx;
   logic [31:0]         r_sdata;
   logic [3:0]          r_rd;

   logic                r_stall;
   logic                r_wb_en;
   logic [3:0]          r_wb_addr;
   logic [31:0]         r_wb_data;
   logic                r_br;
   logic                r_jmp;
   logic                r_aerr;

   logic [31:0]         r_ram [DEPTH];

   logic [ADDR_W-1:0]   w_idx_in;
   logic                w_mis_in;
   logic                w_commit;
   logic                w_ram_we;
   logic [ADDR_W-1:0]   w_ram_idx;
   logic [31:0]         w_ram_wdata;
   logic [31:0]         w_ram_rdata;

   // Upper address bits drop out here, so addresses wrap modulo DEPTH.
   assign w_idx_in = alu_in[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
   assign w_mis_in = (alu_in[1:0] != 2'b00);
`else
   assign w_mis_in = 1'b0;
`endif

   assign w_commit = (r_state == S_WAIT) && (r_cnt == 3'd1);

   // One shared RAM port: the latched index at commit, otherwise the live
   // input index, which only the zero-wait-state path uses.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_idx   = w_idx_in;
      w_ram_wdata = read_data2_in;
      if (w_commit) begin
         w_ram_idx   = r_idx;
         w_ram_wdata = r_sdata;
         w_ram_we    = !r_is_load && !r_mis;
      end else if (LAT0 && (r_state == S_IDLE) && valid_in &&
                   (opcode_in == OP_STORE) && !w_mis_in) begin
         w_ram_we = 1'b1;
      end
      // A clock edge seen during reset must not write the RAM. This covers
      // an aborted op.
      w_ram_we = w_ram_we & rst_n;
   end

   assign w_ram_rdata = r_ram[w_ram_idx];

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_ram_idx] <= w_ram_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 3'd0;
         r_is_load <= 1'b0;
         r_mis     <= 1'b0;
         r_idx     <= '0;
         r_sdata   <= 32'd0;
         r_rd      <= 4'd0;
         r_stall   <= 1'b0;
         r_wb_en   <= 1'b0;
         r_wb_addr <= 4'd0;
         r_wb_data <= 32'd0;
         r_br      <= 1'b0;
         r_jmp     <= 1'b0;
         r_aerr    <= 1'b0;
      end else begin
         r_wb_en <= 1'b0;
         r_br    <= 1'b0;
         r_jmp   <= 1'b0;
         r_aerr  <= 1'b0;
         if (r_state == S_IDLE) begin
            if (valid_in) begin
               case (opcode_in)
                  4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1001: begin
                     r_wb_en   <= 1'b1;
                     r_wb_addr <= regdst_in;
                     r_wb_data <= alu_in;
                  end
                  OP_BEQ: r_br  <= cmp_in;
                  OP_BNE: r_br  <= ~cmp_in;
                  OP_JMP: r_jmp <= 1'b1;
                  OP_LOAD, OP_STORE: begin
                     if (LAT0) begin
                        if (w_mis_in) begin
                           r_aerr <= 1'b1;
                        end else if (opcode_in == OP_LOAD) begin
                           r_wb_en   <= 1'b1;
                           r_wb_addr <= regdst_in;
                           r_wb_data <= w_ram_rdata;
                        end
                     end else begin
                        r_state   <= S_WAIT;
                        r_stall   <= 1'b1;
                        r_cnt     <= LAT3;
                        r_is_load <= (opcode_in == OP_LOAD);
                        r_mis     <= w_mis_in;
                        r_idx     <= w_idx_in;
                        r_sdata   <= read_data2_in;
                        r_rd      <= regdst_in;
                     end
                  end
                  default: ;
               endcase
            end
         end else begin
            if (r_cnt == 3'd1) begin
               r_state <= S_IDLE;
               r_stall <= 1'b0;
               r_cnt   <= 3'd0;
               if (r_mis) begin
                  r_aerr <= 1'b1;
               end else if (r_is_load) begin
                  r_wb_en   <= 1'b1;
                  r_wb_addr <= r_rd;
                  r_wb_data <= w_ram_rdata;
               end
            end else begin
               r_cnt <= r_cnt - 3'd1;
            end
         end
      end
   end

   assign stall        = r_stall;
   assign wb_en        = r_wb_en;
   assign wb_addr      = r_wb_addr;
   assign wb_data      = r_wb_data;
   assign branch_taken = r_br;
   assign jump_taken   = r_jmp;
   assign align_err    = r_aerr;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] alu_in = 32'd0;
   logic [3:0]  opcode_in = 4'd0;
   logic [3:0]  regdst_in = 4'd0;
   logic [31:0] read_data2_in = 32'd0;
   logic        cmp_in = 1'b0;
   logic        stall, wb_en, branch_taken, jump_taken, align_err;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: memory contents and the expected held writeback port.
   logic [31:0] mem_m [256];
   logic [3:0]  exp_addr = 4'd0;
   logic [31:0] exp_data = 32'd0;

   mem_wb_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_in(alu_in),
      .opcode_in(opcode_in), .regdst_in(regdst_in),
      .read_data2_in(read_data2_in), .cmp_in(cmp_in), .stall(stall),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .branch_taken(branch_taken), .jump_taken(jump_taken),
      .align_err(align_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string ctx, input logic we, input logic br,
                             input logic jt, input logic ae, input logic st);
      chk({ctx, ".wb_en"}, 32'(wb_en), 32'(we));
      chk({ctx, ".branch"}, 32'(branch_taken), 32'(br));
      chk({ctx, ".jump"}, 32'(jump_taken), 32'(jt));
      chk({ctx, ".align"}, 32'(align_err), 32'(ae));
      chk({ctx, ".stall"}, 32'(stall), 32'(st));
      chk({ctx, ".wb_addr"}, 32'(wb_addr), 32'(exp_addr));
      chk({ctx, ".wb_data"}, wb_data, exp_data);
   endtask

   function automatic logic misaligned(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
      return (a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   // Presents one instruction from idle, checks it through retirement, then
   // checks one quiet cycle so that every pulse is exactly one cycle wide.
   task automatic issue(input string ctx, input logic [3:0] op, input logic [31:0] a,
                        input logic [3:0] rd, input logic [31:0] d2, input logic c);
      int idx;
      logic we, br, jt;
      @(negedge clk);
      opcode_in = op; alu_in = a; regdst_in = rd; read_data2_in = d2; cmp_in = c;
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      idx = int'((a >> 2) % 256);
      if (op == 4'd4 || op == 4'd5) begin
         for (int k = 0; k < LAT; k++) begin
            check_outs({ctx, ".wait"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            @(posedge clk); #1;
         end
         if (misaligned(a)) begin
            check_outs({ctx, ".commit"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         end else if (op == 4'd4) begin
            exp_addr = rd; exp_data = mem_m[idx];
            check_outs({ctx, ".commit"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         end else begin
            mem_m[idx] = d2;
            check_outs({ctx, ".commit"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
      end else begin
         we = (op <= 4'd3) || op == 4'd8 || op == 4'd9;
         br = (op == 4'd6) ? c : (op == 4'd7) ? !c : 1'b0;
         jt = (op == 4'd10);
         if (we) begin exp_addr = rd; exp_data = a; end
         check_outs({ctx, ".accept"}, we, br, jt, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      check_outs({ctx, ".quiet"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] a;
      logic [3:0]  op;

      repeat (3) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // idle with valid_in low: nothing happens
      repeat (2) @(posedge clk);
      #1;
      check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      issue("alu0", 4'd0, 32'h5, 4'd3, 32'd0, 1'b0);
      issue("st10", 4'd5, 32'h10, 4'd0, 32'hDEADBEEF, 1'b0);
      issue("ld10", 4'd4, 32'h10, 4'd7, 32'd0, 1'b0);
      issue("stwrap", 4'd5, 32'h400, 4'd0, 32'h1234, 1'b0);
      issue("ldwrap", 4'd4, 32'h0, 4'd1, 32'd0, 1'b0);
      issue("beq", 4'd6, 32'h0, 4'd0, 32'd0, 1'b1);
      issue("bne", 4'd7, 32'h0, 4'd0, 32'd0, 1'b1);
      issue("bne0", 4'd7, 32'h0, 4'd0, 32'd0, 1'b0);
      issue("jmp", 4'd10, 32'h0, 4'd5, 32'd0, 1'b0);
      issue("nop", 4'd12, 32'hFFFF, 4'd6, 32'd0, 1'b1);

      // Hold during stall: ALU op presented while the load is pending.
      @(negedge clk);
      opcode_in = 4'd4; alu_in = 32'h10; regdst_in = 4'd7; valid_in = 1'b1;
      @(posedge clk); #1;
      opcode_in = 4'd2; alu_in = 32'd9; regdst_in = 4'd2;
      for (int k = 0; k < LAT; k++) begin
         check_outs("hold.wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         @(posedge clk); #1;
      end
      exp_addr = 4'd7; exp_data = mem_m[4];
      check_outs("hold.load", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      valid_in = 1'b0;
      exp_addr = 4'd2; exp_data = 32'd9;
      check_outs("hold.alu", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_outs("hold.quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during WAIT aborts the store.
      issue("st20", 4'd5, 32'h20, 4'd0, 32'h55, 1'b0);
      @(negedge clk);
      opcode_in = 4'd5; alu_in = 32'h20; read_data2_in = 32'hBAD; valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      check_outs("abort.wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      exp_addr = 4'd0; exp_data = 32'd0;
      check_outs("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      issue("ld20", 4'd4, 32'h20, 4'd9, 32'd0, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
      issue("ldmis", 4'd4, 32'h22, 4'd4, 32'd0, 1'b0);
      issue("stmis", 4'd5, 32'h21, 4'd0, 32'hCAFE, 1'b0);
      issue("ld20b", 4'd4, 32'h20, 4'd4, 32'd0, 1'b0);
`endif

      // Seed a small window of words so random loads hit known data.
      for (int i = 0; i < 16; i++)
         issue("seed", 4'd5, 32'(i << 2), 4'd0, $urandom, 1'b0);

      for (int n = 0; n < 200; n++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         if (op == 4'd4 || op == 4'd5)
            a[9:2] = 8'($urandom_range(0, 15));
         issue("rand", op, a, 4'($urandom), $urandom, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
